// File: rtl/aux_input_conditioner_pkg.sv
// Shared definitions for the auxiliary input conditioner: cycle-count helpers,
// repeat FSM state encoding and counter sizing.
package aux_input_conditioner_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;

    function automatic int unsigned cnt_hz(input int unsigned freq_hz);
        return CLK_HZ / freq_hz;
    endfunction

    function automatic int unsigned cnt_khz(input int unsigned freq_khz);
        return CLK_HZ / (freq_khz * 1000);
    endfunction

    function automatic int unsigned cnt_mhz(input int unsigned freq_mhz);
        return CLK_HZ / (freq_mhz * 1_000_000);
    endfunction

    // Width able to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    typedef enum logic [1:0] {
        AIC_ST_IDLE   = 2'd0,
        AIC_ST_DELAY  = 2'd1,
        AIC_ST_REPEAT = 2'd2
    } aic_state_e;

endpackage

// File: rtl/aux_debounce_channel.sv
// One input channel: synchronizer chain, stable-count debouncer, edge pulses
// and the press auto-repeat state machine.
module aux_debounce_channel
    import aux_input_conditioner_pkg::*;
#(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned DebounceCnt  = 4,
    parameter int unsigned RepeatDelay  = 0,
    parameter int unsigned RepeatPeriod = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic press_pulse,
    output logic change_nxt
);

    localparam int unsigned DBC_W = cnt_w(DebounceCnt);
    localparam int unsigned RPT_W = cnt_w((RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DebounceCnt - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(RepeatDelay - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(RepeatPeriod - 1);
    localparam bit RPT_EN = (RepeatDelay != 0);

    logic [SyncStages-1:0] sync_p0;
    logic                  sync;
    logic [DBC_W-1:0]      dbc_cnt_p1;
    aic_state_e            state_p1;
    logic [RPT_W-1:0]      rpt_cnt_p1;
    logic                  accept;
    logic                  rise;
    logic                  fall;
    logic                  rpt_due;

    assign sync       = sync_p0[SyncStages-1];
    assign change_nxt = accept;

    always_comb begin
        accept  = (sync != level_out) && (dbc_cnt_p1 == DBC_LAST);
        rise    = accept && sync;
        fall    = accept && !sync;
        rpt_due = 1'b0;
        // A fall landing on a due repeat suppresses that repeat.
        if (!fall) begin
            if (state_p1 == AIC_ST_DELAY && rpt_cnt_p1 == DLY_LAST) begin
                rpt_due = 1'b1;
            end
            if (state_p1 == AIC_ST_REPEAT && rpt_cnt_p1 == PER_LAST) begin
                rpt_due = 1'b1;
            end
        end
    end

    // Stage p0: synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SyncStages-2:0], raw_in};
        end
    end

    // Stage p1: debounce counter, accepted level and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbc_cnt_p1 <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= rise;
            fall_pulse <= fall;
            if (sync == level_out) begin
                dbc_cnt_p1 <= '0;
            end else if (accept) begin
                level_out  <= sync;
                dbc_cnt_p1 <= '0;
            end else begin
                dbc_cnt_p1 <= dbc_cnt_p1 + DBC_W'(1);
            end
        end
    end

    // Stage p1: auto-repeat FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1    <= AIC_ST_IDLE;
            rpt_cnt_p1  <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= rise || rpt_due;
            if (fall) begin
                state_p1   <= AIC_ST_IDLE;
                rpt_cnt_p1 <= '0;
            end else begin
                case (state_p1)
                    AIC_ST_IDLE: begin
                        if (rise && RPT_EN) begin
                            state_p1   <= AIC_ST_DELAY;
                            rpt_cnt_p1 <= '0;
                        end
                    end
                    AIC_ST_DELAY: begin
                        if (rpt_cnt_p1 == DLY_LAST) begin
                            state_p1   <= AIC_ST_REPEAT;
                            rpt_cnt_p1 <= '0;
                        end else begin
                            rpt_cnt_p1 <= rpt_cnt_p1 + RPT_W'(1);
                        end
                    end
                    AIC_ST_REPEAT: begin
                        if (rpt_cnt_p1 == PER_LAST) begin
                            rpt_cnt_p1 <= '0;
                        end else begin
                            rpt_cnt_p1 <= rpt_cnt_p1 + RPT_W'(1);
                        end
                    end
                    default: begin
                        state_p1   <= AIC_ST_IDLE;
                        rpt_cnt_p1 <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/aux_input_conditioner.sv
// Conditions Width asynchronous board inputs into debounced levels, edge
// pulses and optional auto-repeat press pulses.
module aux_input_conditioner
    import aux_input_conditioner_pkg::*;
#(
    parameter int unsigned Width        = 16,
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned DebounceCnt  = cnt_khz(100),
    parameter int unsigned RepeatDelay  = 0,
    parameter int unsigned RepeatPeriod = cnt_hz(10)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] raw_in,
    output logic [Width-1:0] level_out,
    output logic [Width-1:0] rise_pulse,
    output logic [Width-1:0] fall_pulse,
    output logic [Width-1:0] press_pulse,
    output logic             any_change
);

    logic [Width-1:0] change_nxt;

    for (genvar i = 0; i < Width; i++) begin : g_chan
        aux_debounce_channel #(
            .SyncStages  (SyncStages),
            .DebounceCnt (DebounceCnt),
            .RepeatDelay (RepeatDelay),
            .RepeatPeriod(RepeatPeriod)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw_in     (raw_in[i]),
            .level_out  (level_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .press_pulse(press_pulse[i]),
            .change_nxt (change_nxt[i])
        );
    end

    // Registered from the channels' acceptance strobes so it lines up with the edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |change_nxt;
        end
    end

endmodule

// File: tb/tb_aux_input_conditioner.sv
// Self-checking bench for aux_input_conditioner: directed scenarios plus
// randomized input activity against a window-based behavioural model.
module tb_aux_input_conditioner;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] level_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] press_pulse;
    logic         any_change;

    aux_input_conditioner #(
        .Width       (W),
        .SyncStages  (SS),
        .DebounceCnt (DC),
        .RepeatDelay (RD),
        .RepeatPeriod(RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .press_pulse(press_pulse),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: edge count since reset release, raw level sampled at each edge,
    // accepted levels and the edge of the latest accepted rise per channel.
    int           t = 0;
    logic [W-1:0] raw_at [0:4095];
    logic [W-1:0] m_level = '0;
    int           rise_t [W];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d act=%0h exp=%0h", tag, t, act, exp);
        end
    endtask

    // Raw level that the debouncer looks at on edge n (delayed by the synchronizer).
    function automatic logic samp(input int n, input int ch);
        int idx = n - SS;
        if (idx < 1) return 1'b0;
        return raw_at[idx][ch];
    endfunction

    task automatic step();
        logic [W-1:0] nl;
        logic [W-1:0] e_rise;
        logic [W-1:0] e_fall;
        logic [W-1:0] e_press;
        @(posedge clk);
        t++;
        if (t < 4096) raw_at[t] = raw_in;
        nl = m_level; e_rise = '0; e_fall = '0; e_press = '0;
        for (int ch = 0; ch < W; ch++) begin
            bit acc = 1'b1;
            for (int k = 0; k < DC; k++) begin
                if (samp(t - k, ch) == m_level[ch]) acc = 1'b0;
            end
            if (acc) begin
                nl[ch] = ~m_level[ch];
                if (nl[ch]) begin
                    e_rise[ch] = 1'b1;
                    rise_t[ch] = t;
                end else begin
                    e_fall[ch] = 1'b1;
                end
            end
            if (e_rise[ch]) begin
                e_press[ch] = 1'b1;
            end else if (nl[ch] && RD != 0) begin
                int d = t - rise_t[ch];
                if (d == RD || (d > RD && (d - RD) % RP == 0)) e_press[ch] = 1'b1;
            end
        end
        m_level = nl;
        #1;
        chk("level", 32'(level_out), 32'(m_level));
        chk("rise", 32'(rise_pulse), 32'(e_rise));
        chk("fall", 32'(fall_pulse), 32'(e_fall));
        chk("press", 32'(press_pulse), 32'(e_press));
        chk("any", 32'(any_change), 32'(|(e_rise | e_fall)));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        t       = 0;
        m_level = '0;
        for (int ch = 0; ch < W; ch++) rise_t[ch] = 0;
    endtask

    task automatic assert_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_level", 32'(level_out), 0);
        chk("rst_rise", 32'(rise_pulse), 0);
        chk("rst_fall", 32'(fall_pulse), 0);
        chk("rst_press", 32'(press_pulse), 0);
        chk("rst_any", 32'(any_change), 0);
        @(posedge clk);
        release_reset();
    endtask

    // Wait (bounded) for a rise or fall pulse on a channel; -1 on timeout.
    task automatic wait_pulse(input int ch, input bit want_fall, output int tt);
        tt = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if ((want_fall ? fall_pulse[ch] : rise_pulse[ch]) == 1'b1) begin
                tt = t;
                break;
            end
        end
    endtask

    initial begin
        int t0;
        int tt;
        int lat;
        int nac;
        logic [31:0] pv;
        logic [W-1:0] rp;
        bit seen;

        // Power-on reset
        #1;
        chk("por_level", 32'(level_out), 0);
        chk("por_any", 32'(any_change), 0);
        #11;
        release_reset();
        steps(10);
        raw_in = 4'hF;
        steps(12);

        // Asynchronous reset with all inputs high, then re-acceptance at edge 6
        assert_reset();
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (level_out == 4'hF && lat < 0) lat = t;
        end
        chk("rst_relatch", 32'(lat), 6);

        // Single channel rise
        raw_in = '0;
        steps(12);
        t0 = t;
        raw_in[0] = 1'b1;
        wait_pulse(0, 1'b0, tt);
        chk("lat_rise0", 32'(tt - t0), 6);

        // Short glitch rejected, minimum-length pulse accepted
        raw_in = '0;
        steps(12);
        seen = 1'b0;
        raw_in[1] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) raw_in[1] = 1'b0;
            step();
            if (level_out[1] || rise_pulse[1]) seen = 1'b1;
        end
        chk("glitch3", 32'(seen), 0);
        t0 = t;
        raw_in[1] = 1'b1;
        steps(4);
        raw_in[1] = 1'b0;
        wait_pulse(1, 1'b0, tt);
        chk("pulse4_rise", 32'(tt - t0), 6);
        wait_pulse(1, 1'b1, tt);
        chk("pulse4_fall", 32'(tt - t0), 10);

        // Auto-repeat sequence and fall that collides with a due repeat
        steps(8);
        raw_in[2] = 1'b1;
        wait_pulse(2, 1'b0, t0);
        pv = '0;
        tt = -1;
        if (press_pulse[2]) pv[0] = 1'b1;
        for (int off = 1; off <= 22; off++) begin
            step();
            if (press_pulse[2]) pv[off] = 1'b1;
            if (fall_pulse[2]) tt = off;
            if (off == 13) raw_in[2] = 1'b0;
        end
        chk("repeat_seq", pv, 32'h0001_2401);
        chk("repeat_fall", 32'(tt), 19);

        // Simultaneous rises on two channels
        raw_in = '0;
        steps(12);
        raw_in = 4'b1010;
        nac = 0;
        rp = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (any_change) begin
                nac++;
                rp = rise_pulse;
            end
        end
        chk("simul_rise", 32'(rp), 32'h0000_000A);
        chk("simul_any", 32'(nac), 1);

        // Reset in the middle of the repeat delay
        raw_in = '0;
        steps(12);
        raw_in[2] = 1'b1;
        wait_pulse(2, 1'b0, tt);
        steps(8);
        assert_reset();
        wait_pulse(2, 1'b0, tt);
        chk("rerst_lat", 32'(tt), 6);
        pv = '0;
        if (press_pulse[2]) pv[0] = 1'b1;
        for (int off = 1; off <= 17; off++) begin
            step();
            if (press_pulse[2]) pv[off] = 1'b1;
        end
        chk("rerst_seq", pv, 32'h0001_2401);

        // Randomized activity with varying toggle density
        for (int blk = 0; blk < 15; blk++) begin
            int div;
            case ($urandom_range(0, 2))
                0: div = 3;
                1: div = 8;
                default: div = 40;
            endcase
            for (int i = 0; i < 100; i++) begin
                for (int ch = 0; ch < W; ch++) begin
                    if ($urandom_range(0, div - 1) == 0) raw_in[ch] = ~raw_in[ch];
                end
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
